svi_rr_arbiter: RTL and testbench
=================================

# svi_rr_arbiter

Round-robin arbiter that shares one downstream resource among `N_REQ` requesters, each attached through one element of an array of SystemVerilog interface ports. It sits between an array of requester modules and the shared resource. It grants exclusive ownership to one requester at a time and enforces a maximum hold time. It reports the current owner, busy state and timeout events to the resource side.

## Interface
Interface `arb_if` has members `req`, `done` and `gnt`, all scalar `logic`. Its modport `A` is `input req, input done, output gnt`.

Parameters:
- `N_REQ`, 8: number of requesters; legal range 2..32.
- `MAX_HOLD`, 15: maximum consecutive cycles `gnt` may stay high for one owner; legal range 1..255.
- `OW`, `$clog2(N_REQ)`: owner index width; derived, not overridden.

Ports:
- `i_clk`, input, 1: single clock; all logic on its rising edge.
- `i_arst_n`, input, 1: reset, asynchronous assert, active-low; release is synchronous to `i_clk` by the integrator.
- `p`, `arb_if.A` array, `[N_REQ-1:0]`: per-requester request, done and grant.
- `o_busy`, output, 1: high while any grant is active.
- `o_owner`, output, `OW`: index of the current grantee; holds the last value when not busy.
- `o_timeout`, output, 1: one-cycle pulse when a grant is revoked by the hold limit.
- `o_timeout_cnt`, output, 8: saturating count of timeouts since reset.

## Operation
Registered state:
- `state`, one of IDLE or GRANT.
- `last`, `OW` bits: round-robin pointer.
- `hold`, `$clog2(MAX_HOLD+1)` bits: hold counter.
- the per-requester `gnt` flops.
- `o_timeout`, `o_timeout_cnt`.

Reset values:
- `state` = IDLE.
- all `p[i].gnt` = 0, `o_busy` = 0, `o_timeout` = 0, `o_timeout_cnt` = 0.
- `o_owner` = 0.
- `last` = N_REQ-1, so requester 0 has first priority.

Arbitration:
- Search `p[i].req` starting at index `last+1` and wrapping modulo N_REQ. The first asserted index wins.
- The winner is written to `o_owner` and `last`.

State machine:
- IDLE, at least one `req` high: set winner `gnt`=1, `hold`=0, go to GRANT.
- IDLE, no `req`: stay in IDLE.
- GRANT, owner `done`=1 or owner `req`=0: clear `gnt`, go to IDLE (normal release).
- GRANT, otherwise with `hold` == MAX_HOLD-1: clear `gnt`, go to IDLE, set `o_timeout`=1 for the next cycle, increment `o_timeout_cnt` (saturates at 255).
- GRANT, otherwise: `hold` += 1, stay in GRANT.

Outputs and rules:
- `o_busy` equals `state==GRANT`.
- At most one `gnt` is high in any cycle. This is a one-hot-or-zero invariant.
- `req` and `done` from non-owners are ignored while in GRANT.
- `done` is ignored in IDLE.
- A requester with `req` held high continuously is re-granted only after every other active requester has been served once.

## Timing
- Grant latency: `req` high at edge k while IDLE gives `gnt` high after edge k, visible in cycle k+1.
- Release: owner `done` sampled at edge m gives `gnt` low in cycle m+1. State is IDLE in cycle m+1. The next grant is visible in cycle m+2, so there is exactly one idle cycle between grants.
- Simultaneous `done` and hold limit at the same edge: treated as a normal release; no timeout pulse, no count.
- Timeout: `gnt` is high for exactly MAX_HOLD cycles. `o_timeout` is high in the first IDLE cycle after the revoke, for one cycle only.
- The revoked owner loses priority normally because `last` is already pointing at it.
- Reset asserted mid-grant: all `gnt` drop immediately (asynchronously); all state returns to reset values.
- `req` must be held until `gnt` is seen. Dropping `req` before the grant simply removes it from the next arbitration.

## Test plan
- Reset, then `p[3].req`=1 alone: `p[3].gnt` rises 1 cycle later; `o_owner`=3, `o_busy`=1; `o_timeout`=0.
- All 8 `req` held high, each owner pulses `done` 2 cycles after its grant: grant order 0,1,2,...,7,0 with one idle cycle between grants; never two `gnt` high at once.
- `p[5]` granted and never asserts `done`, MAX_HOLD=15: `gnt` high exactly 15 cycles; `o_timeout` pulses once; `o_timeout_cnt`=1; next grant goes to the next requesting index after 5.
- `done` asserted on the 15th grant cycle, together with the hold limit: normal release; `o_timeout` stays 0; `o_timeout_cnt` is unchanged.
- Owner drops `req` without `done`; a non-owner asserts `done` during GRANT: the owner's drop releases the grant; the stray `done` has no effect.
- Force 256 timeouts: `o_timeout_cnt` saturates at 255. Then assert `i_arst_n`=0 mid-grant: `gnt` drops without waiting for a clock edge; all outputs read their reset values.

Source files
------------

// File: rtl/svi_rr_arbiter_if.sv
// Per-requester handshake bundle between one requester and the round-robin arbiter.
// The arbiter sees req/done as inputs and drives gnt.
interface arb_if;
  logic req;
  logic done;
  logic gnt;

  modport A (input req, input done, output gnt);
endinterface

// File: rtl/svi_rr_arbiter.sv
// Round-robin arbiter granting one requester at a time, with a bounded hold time,
// a one-cycle timeout pulse and a saturating timeout counter.
module svi_rr_arbiter #(
  parameter  int N_REQ    = 8,
  parameter  int MAX_HOLD = 15,
  localparam int OW       = $clog2(N_REQ)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  arb_if.A              p [N_REQ-1:0],
  output logic          o_busy,
  output logic [OW-1:0] o_owner,
  output logic          o_timeout,
  output logic [7:0]    o_timeout_cnt
);

  localparam int                HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N_REQ-1:0]  ONE       = N_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q;
  logic [OW-1:0]     last_q;
  logic [OW-1:0]     owner_q;
  logic [HW-1:0]     hold_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              timeout_q;
  logic [7:0]        tcnt_q;

  logic [N_REQ-1:0]  req_v;
  logic [N_REQ-1:0]  done_v;
  logic [OW-1:0]     win_d;

  for (genvar i = 0; i < N_REQ; i++) begin : g_port
    assign req_v[i]  = p[i].req;
    assign done_v[i] = p[i].done;
    assign p[i].gnt  = gnt_q[i];
  end

  // Scan downward in distance from the pointer so the nearest requester after
  // last_q overwrites all others; distance N_REQ lets a lone requester win again.
  // NOTE: win_d gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    win_d = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_v[(int'(last_q) + k) % N_REQ]) win_d = OW'((int'(last_q) + k) % N_REQ);
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= IDLE;
      last_q    <= OW'(N_REQ - 1);
      owner_q   <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_v) begin
            state_q <= GRANT;
            gnt_q   <= ONE << win_d;
            owner_q <= win_d;
            last_q  <= win_d;
            hold_q  <= '0;
          end
        end
        GRANT: begin
          // A release on the limit cycle wins over the timeout.
          if (done_v[owner_q] || !req_v[owner_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
          end else if (hold_q == HOLD_LAST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            timeout_q <= 1'b1;
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy        = (state_q == GRANT);
  assign o_owner       = owner_q;
  assign o_timeout     = timeout_q;
  assign o_timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_svi_rr_arbiter.sv
// Self-checking bench for svi_rr_arbiter: directed scenarios plus random traffic,
// compared against a cycle-level reference model of the arbitration rules.
module tb_svi_rr_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_v = '0;
  logic [N-1:0] done_v = '0;
  logic [N-1:0] gnt_v;
  logic         busy;
  logic [2:0]   owner;
  logic         timeout;
  logic [7:0]   tcnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy, m_timeout;
  int m_owner, m_last, m_gcycles, m_tcnt;

  arb_if u_if [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_if
    assign u_if[g].req  = req_v[g];
    assign u_if[g].done = done_v[g];
    assign gnt_v[g]     = u_if[g].gnt;
  end

  svi_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk         (clk),
    .i_arst_n      (rst_n),
    .p             (u_if),
    .o_busy        (busy),
    .o_owner       (owner),
    .o_timeout     (timeout),
    .o_timeout_cnt (tcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    return m_busy ? N'(1) << m_owner : '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_timeout = 0; m_owner = 0; m_last = N - 1; m_gcycles = 0; m_tcnt = 0;
  endtask

  // m_gcycles counts how many cycles the current grant has already been visible.
  task automatic model_step();
    m_timeout = 0;
    if (!m_busy) begin
      if (req_v != '0) begin
        m_owner   = rr_pick(m_last, req_v);
        m_last    = m_owner;
        m_busy    = 1;
        m_gcycles = 1;
      end
    end else if (done_v[m_owner] || !req_v[m_owner]) begin
      m_busy = 0;
    end else if (m_gcycles == MAX_HOLD) begin
      m_busy    = 0;
      m_timeout = 1;
      if (m_tcnt < 255) m_tcnt++;
    end else begin
      m_gcycles++;
    end
  endtask

  // Inputs change only at negedge, so the model sees exactly what the DUT samples.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req_v = '0; done_v = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt_v !== '0) begin errors++; $display("FAIL reset_gnt: got %h, want 00", gnt_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d, want 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, want 0", timeout); end
    checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL reset_tcnt: got %0d, want 0", tcnt); end
  endtask

  task automatic test_single_grant();
    apply_reset();
    req_v = 8'h08;
    checks++; if (gnt_v !== '0) begin errors++; $display("FAIL single_latency: got %h before edge, want 00", gnt_v); end
    tick();
    checks++; if (gnt_v !== 8'h08) begin errors++; $display("FAIL single_gnt: got %h, want 08", gnt_v); end
    checks++; if (owner !== 3'd3) begin errors++; $display("FAIL single_owner: got %0d, want 3", owner); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, want 1", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b, want 0", timeout); end
    req_v = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps[$];
    int idle_run;
    logic [N-1:0] prev;
    apply_reset();
    req_v = '1;
    prev = '0;
    idle_run = 0;
    for (int c = 0; c < 200 && order.size() < 9; c++) begin
      done_v = (m_busy && m_gcycles == 2) ? N'(1) << m_owner : '0;
      tick();
      checks++; if (gnt_v !== exp_gnt()) begin errors++; $display("FAIL rr_gnt: cycle %0d got %h, want %h", c, gnt_v, exp_gnt()); end
      checks++; if (!$onehot0(gnt_v)) begin errors++; $display("FAIL rr_onehot: got %h, want one-hot-or-zero", gnt_v); end
      if (gnt_v != '0 && prev == '0) begin
        for (int i = 0; i < N; i++) if (gnt_v[i]) order.push_back(i);
        gaps.push_back(idle_run);
        idle_run = 0;
      end else if (gnt_v == '0) begin
        idle_run++;
      end
      prev = gnt_v;
    end
    done_v = '0;
    checks++; if (order.size() != 9) begin errors++; $display("FAIL rr_count: got %0d grants, want 9", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
      checks++; if (order[i] != i % N) begin errors++; $display("FAIL rr_order: grant %0d got %0d, want %0d", i, order[i], i % N); end
      if (i > 0) begin
        checks++; if (gaps[i] != 1) begin errors++; $display("FAIL rr_gap: before grant %0d got %0d idle, want 1", i, gaps[i]); end
      end
    end
    req_v = '0;
    tick();
  endtask

  task automatic test_timeout();
    int high;
    int exp_next;
    apply_reset();
    req_v = 8'h20 | {$urandom_range(0, 3), 6'b0};
    tick();
    checks++; if (owner !== 3'd5 || gnt_v !== 8'h20) begin errors++; $display("FAIL to_first: got owner %0d gnt %h, want 5 / 20", owner, gnt_v); end
    high = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt_v[5]) high++;
      else break;
    end
    checks++; if (high != MAX_HOLD) begin errors++; $display("FAIL to_hold: got %0d cycles, want %0d", high, MAX_HOLD); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b, want 1", timeout); end
    checks++; if (tcnt !== 8'd1) begin errors++; $display("FAIL to_cnt: got %0d, want 1", tcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy %b, want 0", busy); end
    exp_next = rr_pick(5, req_v);
    tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b, want 0", timeout); end
    checks++; if (owner !== 3'(exp_next) || gnt_v !== N'(1) << exp_next) begin
      errors++; $display("FAIL to_next: got owner %0d gnt %h, want %0d", owner, gnt_v, exp_next);
    end
    req_v = '0;
    tick();
  endtask

  task automatic test_done_at_limit();
    int k;
    apply_reset();
    k = $urandom_range(0, N - 1);
    req_v = N'(1) << k;
    tick();
    for (int c = 0; c < 40 && m_gcycles < MAX_HOLD; c++) tick();
    checks++; if (gnt_v !== N'(1) << k) begin errors++; $display("FAIL lim_still_granted: got %h, want %h", gnt_v, N'(1) << k); end
    done_v = N'(1) << k;
    tick();
    checks++; if (gnt_v !== '0) begin errors++; $display("FAIL lim_release: got %h, want 00", gnt_v); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL lim_timeout: got %b, want 0", timeout); end
    checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL lim_cnt: got %0d, want 0", tcnt); end
    done_v = '0; req_v = '0;
    tick();
  endtask

  task automatic test_release_rules();
    int a, b;
    apply_reset();
    a = $urandom_range(0, N - 1);
    b = (a + $urandom_range(1, N - 1)) % N;
    req_v = N'(1) << a;
    tick();
    done_v = N'(1) << b;
    req_v  = req_v | N'(1) << b;
    repeat (2) begin
      tick();
      checks++; if (gnt_v !== N'(1) << a || busy !== 1'b1) begin
        errors++; $display("FAIL stray_done: got gnt %h busy %b, want %h / 1", gnt_v, busy, N'(1) << a);
      end
    end
    done_v = '0;
    req_v  = N'(1) << b;
    tick();
    checks++; if (gnt_v !== '0 || busy !== 1'b0) begin errors++; $display("FAIL owner_drop: got gnt %h busy %b, want 00 / 0", gnt_v, busy); end
    done_v = N'(1) << b;
    tick();
    checks++; if (gnt_v !== N'(1) << b || owner !== 3'(b)) begin
      errors++; $display("FAIL idle_done_ignored: got gnt %h owner %0d, want %h / %0d", gnt_v, owner, N'(1) << b, b);
    end
    done_v = '0; req_v = '0;
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) req_v[i] = ~req_v[i];
        done_v[i] = ($urandom_range(0, 11) == 0);
      end
      tick();
      checks++; if (gnt_v !== exp_gnt()) begin errors++; $display("FAIL rnd_gnt: cycle %0d got %h, want %h", c, gnt_v, exp_gnt()); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %b, want %b", c, busy, m_busy); end
      checks++; if (owner !== 3'(m_owner)) begin errors++; $display("FAIL rnd_owner: cycle %0d got %0d, want %0d", c, owner, m_owner); end
      checks++; if (timeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout: cycle %0d got %b, want %b", c, timeout, m_timeout); end
      checks++; if (tcnt !== 8'(m_tcnt)) begin errors++; $display("FAIL rnd_tcnt: cycle %0d got %0d, want %0d", c, tcnt, m_tcnt); end
    end
    req_v = '0; done_v = '0;
    tick();
  endtask

  task automatic test_saturate_and_async_reset();
    int pulses;
    bit got_busy;
    apply_reset();
    pulses = 0;
    req_v = 8'h01;
    for (int c = 0; c < 256 * (MAX_HOLD + 1) + 50 && pulses < 256; c++) begin
      tick();
      if (timeout) pulses++;
      if (tcnt !== 8'(m_tcnt)) begin
        checks++; errors++;
        $display("FAIL sat_track: cycle %0d got %0d, want %0d", c, tcnt, m_tcnt);
      end
    end
    checks++; if (pulses != 256) begin errors++; $display("FAIL sat_pulses: got %0d, want 256", pulses); end
    checks++; if (tcnt !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d, want 255", tcnt); end
    got_busy = 0;
    for (int c = 0; c < 5 && !got_busy; c++) begin
      tick();
      got_busy = busy;
    end
    checks++; if (!got_busy) begin errors++; $display("FAIL arst_setup: got busy 0 after 5 cycles, want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt_v !== '0) begin errors++; $display("FAIL arst_gnt: got %h, want 00", gnt_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b, want 0", busy); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL arst_owner: got %0d, want 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL arst_timeout: got %b, want 0", timeout); end
    checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL arst_tcnt: got %0d, want 0", tcnt); end
    req_v = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_release_rules();
    test_random();
    test_saturate_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
